// File: rtl/bnq_pkg.sv
// Shared types and default widths for the batch-norm/quantize parameter sequencer.
package bnq_pkg;

  localparam int DEF_DATA_BITS  = 27;
  localparam int DEF_PARAM_BITS = 16;
  localparam int DEF_ACT_BITS   = 8;
  localparam int BN_LATENCY     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bnq_param_table.sv
// Per-output-channel scale/bias register file: one write port, one asynchronous read port.
// Contents are deliberately not reset so a layer's table survives a mid-run reset.
module bnq_param_table
  import bnq_pkg::*;
#(
  parameter int PARAM_BITS = DEF_PARAM_BITS,
  parameter int MAX_CH     = 64,
  parameter int CH_W       = 6
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [CH_W-1:0]       i_waddr,
  input  logic [PARAM_BITS-1:0] i_wscale,
  input  logic [PARAM_BITS-1:0] i_wbias,
  input  logic [CH_W-1:0]       i_raddr,
  output logic [PARAM_BITS-1:0] o_scale,
  output logic [PARAM_BITS-1:0] o_bias
);

  logic [2*PARAM_BITS-1:0] r_mem [MAX_CH];

  // Store scale in the upper half and bias in the lower half of each entry.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= {i_wscale, i_wbias};
    end
  end

  assign {o_scale, o_bias} = r_mem[i_raddr];

endmodule

// File: rtl/bnq_param_sequencer.sv
// Layer sequencer for the BN/quantize/activation unit: owns the channel parameter table,
// accepts the accumulator stream, forwards each word with its channel's scale/bias and
// counts results returning from the BN unit to detect layer completion.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready are both high;
// in_ready depends only on the FSM state, never on in_valid.
module bnq_param_sequencer
  import bnq_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int PARAM_BITS = DEF_PARAM_BITS,
  parameter int MAX_CH     = 64,
  parameter int CH_W       = 6,
  parameter int PIX_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [CH_W:0]         cfg_num_ch,
  input  logic [PIX_W-1:0]      cfg_num_pix,
  input  logic [2:0]            cfg_act_shift,
  input  logic [4:0]            cfg_bias_shift,
  input  logic                  cfg_is_last,
  input  logic                  prm_we,
  input  logic [CH_W-1:0]       prm_addr,
  input  logic [PARAM_BITS-1:0] prm_scale,
  input  logic [PARAM_BITS-1:0] prm_bias,
  input  logic                  in_valid,
  input  logic [DATA_BITS-1:0]  in_data,
  output logic                  in_ready,
  output logic [DATA_BITS-1:0]  bn_accum,
  output logic                  bn_accum_vld,
  output logic [PARAM_BITS-1:0] bn_scale,
  output logic [PARAM_BITS-1:0] bn_bias,
  output logic [2:0]            bn_act_shift,
  output logic [4:0]            bn_bias_shift,
  output logic                  bn_is_last_layer,
  input  logic                  bn_vld_out,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  localparam int              OUT_W    = CH_W + 1 + PIX_W;
  localparam logic [CH_W:0]   MAX_CH_V = (CH_W+1)'(MAX_CH);
  localparam logic [CH_W:0]   CH_ONE   = (CH_W+1)'(1);
  localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic [PIX_W-1:0]      r_pix_cnt;
  logic [CH_W-1:0]       r_ch_cnt;
  logic [OUT_W-1:0]      r_out_cnt;
  logic [CH_W:0]         r_num_ch;
  logic [PIX_W-1:0]      r_num_pix;
  logic [2:0]            r_act_shift;
  logic [4:0]            r_bias_shift;
  logic                  r_is_last;
  logic                  r_err;
  logic                  r_err_done;
  logic [DATA_BITS-1:0]  r_bn_accum;
  logic                  r_bn_vld;
  logic [PARAM_BITS-1:0] r_bn_scale;
  logic [PARAM_BITS-1:0] r_bn_bias;

  logic                  w_idle;
  logic                  w_start;
  logic                  w_cfg_bad;
  logic                  w_accept;
  logic                  w_last_pix;
  logic                  w_last_word;
  logic                  w_drain_done;
  logic                  w_tbl_we;
  logic [OUT_W-1:0]      w_total;
  logic [PARAM_BITS-1:0] w_tbl_scale;
  logic [PARAM_BITS-1:0] w_tbl_bias;

  assign w_idle      = (r_state == IDLE);
  assign w_start     = cfg_start && w_idle;
  assign w_cfg_bad   = (cfg_num_ch == '0) || (cfg_num_ch > MAX_CH_V) || (cfg_num_pix == '0);
  assign w_accept    = in_valid && in_ready;
  assign w_last_pix  = (r_pix_cnt == (r_num_pix - PIX_ONE));
  assign w_last_word = w_last_pix && ({1'b0, r_ch_cnt} == (r_num_ch - CH_ONE));
  assign w_total     = OUT_W'(r_num_ch) * OUT_W'(r_num_pix);
  // Writes only land while idle; a write in the start cycle still commits before any accept.
  assign w_tbl_we    = prm_we && w_idle;

  bnq_param_table #(
    .PARAM_BITS (PARAM_BITS),
    .MAX_CH     (MAX_CH),
    .CH_W       (CH_W)
  ) u_table (
    .clk      (clk),
    .i_we     (w_tbl_we),
    .i_waddr  (prm_addr),
    .i_wscale (prm_scale),
    .i_wbias  (prm_bias),
    .i_raddr  (r_ch_cnt),
    .o_scale  (w_tbl_scale),
    .o_bias   (w_tbl_bias)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start && !w_cfg_bad) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_last_word) begin
          w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_out_cnt == w_total) begin
          w_drain_done = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Latched layer config plus pixel/channel/result counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_num_ch     <= '0;
      r_num_pix    <= '0;
      r_act_shift  <= '0;
      r_bias_shift <= '0;
      r_is_last    <= 1'b0;
      r_pix_cnt    <= '0;
      r_ch_cnt     <= '0;
      r_out_cnt    <= '0;
    end else if (w_start) begin
      r_num_ch     <= cfg_num_ch;
      r_num_pix    <= cfg_num_pix;
      r_act_shift  <= cfg_act_shift;
      r_bias_shift <= cfg_bias_shift;
      r_is_last    <= cfg_is_last;
      r_pix_cnt    <= '0;
      r_ch_cnt     <= '0;
      r_out_cnt    <= '0;
    end else begin
      if (w_accept) begin
        if (w_last_pix) begin
          r_pix_cnt <= '0;
          r_ch_cnt  <= r_ch_cnt + CH_W'(1);
        end else begin
          r_pix_cnt <= r_pix_cnt + PIX_ONE;
        end
      end
      if (bn_vld_out && !w_idle) begin
        r_out_cnt <= r_out_cnt + OUT_W'(1);
      end
    end
  end

  // Sticky error flag (cleared by an accepted start) and the done pulse for a rejected config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_done <= 1'b0;
    end else begin
      r_err_done <= w_start && w_cfg_bad;
      if (w_start) begin
        r_err <= w_cfg_bad;
      end
      if ((prm_we && !w_idle) || (cfg_start && !w_idle) || (bn_vld_out && w_idle)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Forward register: word and its channel parameters leave together one cycle after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bn_vld   <= 1'b0;
      r_bn_accum <= '0;
      r_bn_scale <= '0;
      r_bn_bias  <= '0;
    end else begin
      r_bn_vld <= w_accept;
      if (w_accept) begin
        r_bn_accum <= in_data;
        r_bn_scale <= w_tbl_scale;
        r_bn_bias  <= w_tbl_bias;
      end
    end
  end

  assign bn_accum         = r_bn_accum;
  assign bn_accum_vld     = r_bn_vld;
  assign bn_scale         = r_bn_scale;
  assign bn_bias          = r_bn_bias;
  assign bn_act_shift     = r_act_shift;
  assign bn_bias_shift    = r_bias_shift;
  assign bn_is_last_layer = r_is_last;
  assign done             = r_err_done || w_drain_done;
  assign cfg_err          = r_err;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_bnq_param_sequencer.sv
// Directed bench for bnq_param_sequencer with a 4-cycle BN delay model and an
// expected-queue scoreboard on the forward path.
module tb_bnq_param_sequencer;
  import bnq_pkg::*;

  localparam int TB_DW = 27;
  localparam int TB_PW = 16;

  logic             clk;
  logic             reset;
  logic             cfg_start;
  logic [6:0]       cfg_num_ch;
  logic [15:0]      cfg_num_pix;
  logic [2:0]       cfg_act_shift;
  logic [4:0]       cfg_bias_shift;
  logic             cfg_is_last;
  logic             prm_we;
  logic [5:0]       prm_addr;
  logic [TB_PW-1:0] prm_scale;
  logic [TB_PW-1:0] prm_bias;
  logic             in_valid;
  logic [TB_DW-1:0] in_data;
  logic             in_ready;
  logic [TB_DW-1:0] bn_accum;
  logic             bn_accum_vld;
  logic [TB_PW-1:0] bn_scale;
  logic [TB_PW-1:0] bn_bias;
  logic [2:0]       bn_act_shift;
  logic [4:0]       bn_bias_shift;
  logic             bn_is_last_layer;
  logic             bn_vld_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [1:0]       dbg_state;

  bnq_param_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .cfg_start        (cfg_start),
    .cfg_num_ch       (cfg_num_ch),
    .cfg_num_pix      (cfg_num_pix),
    .cfg_act_shift    (cfg_act_shift),
    .cfg_bias_shift   (cfg_bias_shift),
    .cfg_is_last      (cfg_is_last),
    .prm_we           (prm_we),
    .prm_addr         (prm_addr),
    .prm_scale        (prm_scale),
    .prm_bias         (prm_bias),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .bn_accum         (bn_accum),
    .bn_accum_vld     (bn_accum_vld),
    .bn_scale         (bn_scale),
    .bn_bias          (bn_bias),
    .bn_act_shift     (bn_act_shift),
    .bn_bias_shift    (bn_bias_shift),
    .bn_is_last_layer (bn_is_last_layer),
    .bn_vld_out       (bn_vld_out),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset / BN model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] bn_pipe;
  always @(posedge clk or posedge reset) begin
    if (reset) bn_pipe <= '0;
    else       bn_pipe <= {bn_pipe[2:0], bn_accum_vld};
  end
  assign bn_vld_out = bn_pipe[3];

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [TB_DW+2*TB_PW-1:0] exp_q[$];
  logic [TB_PW-1:0] tb_scale [64];
  logic [TB_PW-1:0] tb_bias  [64];
  int cur_npix = 1;
  int acc_idx = 0;
  int last_acc_cyc = 0;
  int vld_cnt = 0;
  int vld_mark;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Forward-path checker: every bn_accum_vld pops one expected word.
  always @(negedge clk) begin
    logic [TB_DW+2*TB_PW-1:0] e;
    if (!reset && bn_accum_vld) begin
      vld_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_vld", 64'(bn_accum_vld), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("bn_accum", 64'(bn_accum), 64'(e[TB_DW+2*TB_PW-1:2*TB_PW]));
        check("bn_scale", 64'(bn_scale), 64'(e[2*TB_PW-1:TB_PW]));
        check("bn_bias",  64'(bn_bias),  64'(e[TB_PW-1:0]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (enter and leave just after a negedge) ----------------
  task automatic write_param(input int addr, input logic [15:0] s, input logic [15:0] b, input bit upd);
    prm_we = 1'b1; prm_addr = 6'(addr); prm_scale = s; prm_bias = b;
    if (upd) begin tb_scale[addr] = s; tb_bias[addr] = b; end
    @(negedge clk);
    prm_we = 1'b0;
  endtask

  task automatic start_layer(input int nch, input int npix, input logic [2:0] act,
                             input logic [4:0] bsh, input logic last, input bit ok);
    cfg_num_ch = 7'(nch); cfg_num_pix = 16'(npix);
    cfg_act_shift = act; cfg_bias_shift = bsh; cfg_is_last = last;
    cfg_start = 1'b1;
    if (ok) begin cur_npix = npix; acc_idx = 0; end
    @(negedge clk);
    cfg_start = 1'b0;
    prm_we = 1'b0;
    if (ok) begin
      check("start_busy", 64'(busy), 64'd1);
      check("start_state", 64'(dbg_state), 64'(RUN));
      check("start_err_clr", 64'(cfg_err), 64'd0);
      check("act_shift", 64'(bn_act_shift), 64'(act));
      check("bias_shift", 64'(bn_bias_shift), 64'(bsh));
      check("is_last", 64'(bn_is_last_layer), 64'(last));
    end
  endtask

  task automatic stream(input int n, input bit rnd);
    int sent = 0;
    int guard = 0;
    int ch;
    logic rdy;
    while (sent < n && guard < 2000) begin
      rdy = in_ready;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = 27'($urandom);
      if (in_valid && rdy) begin
        ch = acc_idx / cur_npix;
        exp_q.push_back({in_data, tb_scale[ch], tb_bias[ch]});
        acc_idx++;
        last_acc_cyc = cyc;
        sent++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("accept_count", 64'(sent), 64'(n));
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("done_latency", 64'(cyc - last_acc_cyc), 64'd6);
    check("busy_at_done", 64'(busy), 64'd1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_pulse_end", 64'(done), 64'd0);
    check("idle_after_done", 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_num_ch = '0; cfg_num_pix = '0;
    cfg_act_shift = '0; cfg_bias_shift = '0; cfg_is_last = 1'b0;
    prm_we = 1'b0; prm_addr = '0; prm_scale = '0; prm_bias = '0;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 64; i++) begin tb_scale[i] = 'x; tb_bias[i] = 'x; end
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);
    check("rst_vld", 64'(bn_accum_vld), 64'd0);

    // Basic two-channel run
    write_param(0, 16'h8000, 16'h0010, 1);
    write_param(1, 16'h4000, 16'hFFF0, 1);
    vld_mark = vld_cnt;
    start_layer(2, 3, 3'd2, 5'd4, 1'b0, 1);
    stream(6, 0);
    wait_done();
    check("basic_vld_count", 64'(vld_cnt - vld_mark), 64'd6);

    // Random upstream stalls
    vld_mark = vld_cnt;
    start_layer(2, 3, 3'd5, 5'd17, 1'b1, 1);
    stream(6, 1);
    wait_done();
    check("stall_vld_count", 64'(vld_cnt - vld_mark), 64'd6);

    // Table write during RUN is dropped
    start_layer(2, 3, 3'd1, 5'd1, 1'b0, 1);
    stream(2, 0);
    write_param(0, 16'hDEAD, 16'hBEEF, 0);
    check("we_in_run_err", 64'(cfg_err), 64'd1);
    stream(4, 0);
    wait_done();

    // Start while busy is ignored
    start_layer(2, 3, 3'd3, 5'd9, 1'b0, 1);
    stream(2, 0);
    start_layer(1, 1, 3'd7, 5'd31, 1'b1, 0);
    check("busy_start_err", 64'(cfg_err), 64'd1);
    check("busy_start_still_busy", 64'(busy), 64'd1);
    check("busy_start_shift_kept", 64'(bn_act_shift), 64'd3);
    stream(4, 0);
    wait_done();

    // Zero channels: rejected, done next cycle, never busy
    start_layer(0, 3, 3'd0, 5'd0, 1'b0, 0);
    check("nch0_done", 64'(done), 64'd1);
    check("nch0_busy", 64'(busy), 64'd0);
    check("nch0_err", 64'(cfg_err), 64'd1);
    @(negedge clk);
    check("nch0_done_end", 64'(done), 64'd0);
    check("nch0_busy_end", 64'(busy), 64'd0);

    // Same-cycle table write and start
    prm_we = 1'b1; prm_addr = 6'd0; prm_scale = 16'h1234; prm_bias = 16'h0010;
    tb_scale[0] = 16'h1234; tb_bias[0] = 16'h0010;
    start_layer(2, 3, 3'd4, 5'd2, 1'b0, 1);
    stream(1, 0);
    check("same_cycle_first_scale", 64'(bn_scale), 64'h1234);
    stream(5, 0);
    wait_done();

    // Reset in the middle of a run
    start_layer(2, 3, 3'd6, 5'd8, 1'b1, 1);
    stream(2, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_vld", 64'(bn_accum_vld), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
    check("mid_rst_scale", 64'(bn_scale), 64'd0);
    check("mid_rst_shift", 64'(bn_act_shift), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    start_layer(2, 3, 3'd2, 5'd3, 1'b0, 1);
    stream(6, 0);
    wait_done();

    // Full table depth, one pixel per channel
    for (int i = 0; i < 64; i++) write_param(i, 16'(i), 16'(16'h0100 + i), 1);
    vld_mark = vld_cnt;
    start_layer(64, 1, 3'd1, 5'd5, 1'b1, 1);
    stream(64, 0);
    check("full_last_scale", 64'(bn_scale), 64'd63);
    wait_done();
    check("full_vld_count", 64'(vld_cnt - vld_mark), 64'd64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
